spr_pipe: RTL and testbench
===========================

SPR_PIPE -- requirements
Module: spr_pipe

Interface
REQ-001 Parameter MEM_WIDTH, default 16, data word width in bits.
REQ-002 Parameter ADD_SIZE, default 10, address width in bits.
REQ-003 Parameter MEM_DEPTH, default 1024, number of words; MEM_DEPTH SHALL be <= 2**ADD_SIZE.
REQ-004 Parameter ADDR_PIPELINE, default 0, 1 = registered request stage.
REQ-005 Parameter DOUT_PIPELINE, default 1, 1 = registered output stage.
REQ-006 Parameter PARITY_ENABLE, default 1, 1 = store and check one parity bit per word.
REQ-007 clk1  in  1  single clock, all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 blk_sel  in  1  block select; request ignored when 0.
REQ-010 wr_en  in  1  write request.
REQ-011 rd_en  in  1  read request.
REQ-012 addr  in  ADD_SIZE  word address.
REQ-013 din  in  MEM_WIDTH  write data.
REQ-014 inj_par  in  1  test only: invert stored parity bit on this write.
REQ-015 addr_en  in  1  request-stage load enable (used only when ADDR_PIPELINE=1).
REQ-016 dout_en  in  1  output-stage load enable (used only when DOUT_PIPELINE=1).
REQ-017 dout  out  MEM_WIDTH  read data.
REQ-018 dout_valid  out  1  dout carries a new read result this cycle.
REQ-019 parity_out  out  1  XOR reduction of dout.
REQ-020 parity_err  out  1  stored parity mismatch on the read shown on dout; qualified by dout_valid.
REQ-021 addr_oor  out  1  one-cycle pulse: accepted request with addr >= MEM_DEPTH.

Function
REQ-022 Accepted request: blk_sel=1 and exactly one of wr_en/rd_en=1; wr_en=rd_en=1 or blk_sel=0 SHALL be a bubble (no access, no valid).
REQ-023 ADDR_PIPELINE=1: request stage loads {op, addr, din, inj_par} when addr_en=1; when addr_en=0 it loads a bubble, previous addr held.
REQ-024 ADDR_PIPELINE=0: request passes combinationally to the memory stage.
REQ-025 Memory stage: write stores din and parity bit (^din) XOR inj_par at the clock edge; read samples word and stored parity bit at the clock edge.
REQ-026 Read-after-write to same address in the next cycle SHALL return the new data; no same-cycle read/write exists (REQ-022).
REQ-027 addr >= MEM_DEPTH: write dropped, read returns all-zero data with parity_err=0; addr_oor pulses with the access.
REQ-028 DOUT_PIPELINE=1: output stage loads read result and valid when dout_en=1; when dout_en=0 holds dout, forces dout_valid=0, arriving result discarded.
REQ-029 DOUT_PIPELINE=0: memory-stage read register drives dout directly.
REQ-030 Read latency from accepted request to dout_valid=1 SHALL be 1 + ADDR_PIPELINE + DOUT_PIPELINE cycles with enables held high.
REQ-031 dout SHALL hold last read data on writes and bubbles; dout_valid=1 only for the cycle a new read result appears.
REQ-032 parity_err = (^data) XOR stored bit of the read presented; PARITY_ENABLE=0: no parity storage, parity_err=0, parity_out=0.
REQ-033 Back-to-back reads SHALL sustain one result per cycle with enables high.

Reset
REQ-034 rst=0 SHALL immediately clear dout, dout_valid, parity_err, addr_oor and all pipeline valid/op state to 0; held addr/din registers cleared to 0.
REQ-035 Memory contents SHALL NOT be reset; reads of unwritten words return undefined data.
REQ-036 Reset mid-operation: in-flight requests discarded, no write completes after rst asserts; first request accepted on the first rising edge with rst=1.

Verification
REQ-037 Defaults: write 0xA5A5 @0x010, read @0x010 next cycle -> dout=0xA5A5, dout_valid=1 two cycles after read, parity_out=0, parity_err=0.
REQ-038 Write 0x0001 @0x3FF with inj_par=1, then read -> dout=0x0001, parity_out=1, parity_err=1; repeat with PARITY_ENABLE=0 -> parity_err=0.
REQ-039 Reads @0..7 back-to-back, dout_en=0 during 4th result cycle -> exactly 7 dout_valid pulses, 4th result lost, dout held during stall.
REQ-040 ADDR_PIPELINE=1, DOUT_PIPELINE=0: read latency 2; addr_en=0 cycle -> no access, no dout_valid.
REQ-041 MEM_DEPTH=1000: write @1000 -> addr_oor pulse, read @1000 -> dout=0; wr_en=rd_en=1 -> no access, no valid.
REQ-042 Assert rst with read in flight -> outputs 0 asynchronously, no dout_valid after release, memory word written before reset still readable.

Source files
------------

// File: rtl/spr_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : spr_pipe_if                                              |
// | Description : Request/response bundle for the spr_pipe single-port     |
// |               RAM. The master modport drives requests and enables;     |
// |               the slave modport (the RAM) returns read data and status.|
// |   blk_sel, wr_en, rd_en, addr, din, inj_par : request                  |
// |   addr_en, dout_en                          : stage load enables       |
// |   dout, dout_valid, parity_out, parity_err, addr_oor : response        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface spr_pipe_if #(
  parameter int MEM_WIDTH = 16,
  parameter int ADD_SIZE  = 10
);
  logic                 blk_sel;
  logic                 wr_en;
  logic                 rd_en;
  logic [ADD_SIZE-1:0]  addr;
  logic [MEM_WIDTH-1:0] din;
  logic                 inj_par;
  logic                 addr_en;
  logic                 dout_en;
  logic [MEM_WIDTH-1:0] dout;
  logic                 dout_valid;
  logic                 parity_out;
  logic                 parity_err;
  logic                 addr_oor;

  modport master (
    output blk_sel, wr_en, rd_en, addr, din, inj_par, addr_en, dout_en,
    input  dout, dout_valid, parity_out, parity_err, addr_oor
  );

  modport slave (
    input  blk_sel, wr_en, rd_en, addr, din, inj_par, addr_en, dout_en,
    output dout, dout_valid, parity_out, parity_err, addr_oor
  );
endinterface
`default_nettype wire

// File: rtl/spr_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : spr_pipe                                                 |
// | Description : Single-port RAM with optional registered request stage,  |
// |               optional registered output stage and per-word parity.    |
// |   clk1 : clock, all state on rising edge                               |
// |   rst  : asynchronous active-low reset                                 |
// |   bus  : spr_pipe_if.slave (request in, read data / status out)        |
// |   The bus interface instance must use the same MEM_WIDTH / ADD_SIZE.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module spr_pipe #(
  parameter int MEM_WIDTH     = 16,
  parameter int ADD_SIZE      = 10,
  parameter int MEM_DEPTH     = 1024,
  parameter int ADDR_PIPELINE = 0,
  parameter int DOUT_PIPELINE = 1,
  parameter int PARITY_ENABLE = 1
) (
  input  logic        clk1,
  input  logic        rst,
  spr_pipe_if.slave   bus
);

  localparam int                c_idx_w = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // One extra bit so a depth of exactly 2**ADD_SIZE is representable.
  localparam logic [ADD_SIZE:0] c_depth = (ADD_SIZE+1)'(MEM_DEPTH);

  // ---------------------------------------------------------------------
  // Request decode: simultaneous read+write or deselected block is a bubble
  // ---------------------------------------------------------------------
  logic accept;
  logic acc_wr;
  logic acc_rd;

  always_comb begin
    accept = bus.blk_sel & (bus.wr_en ^ bus.rd_en);
    acc_wr = accept & bus.wr_en;
    acc_rd = accept & bus.rd_en;
  end

  logic                 req_wr;
  logic                 req_rd;
  logic [ADD_SIZE-1:0]  req_addr;
  logic [MEM_WIDTH-1:0] req_din;
  logic                 req_inj;

  generate
    if (ADDR_PIPELINE != 0) begin : g_addr_pipe
      logic                 req_wr_q,   req_wr_d;
      logic                 req_rd_q,   req_rd_d;
      logic [ADD_SIZE-1:0]  req_addr_q, req_addr_d;
      logic [MEM_WIDTH-1:0] req_din_q,  req_din_d;
      logic                 req_inj_q,  req_inj_d;

      // addr_en low inserts a bubble; address/data registers keep their value.
      always_comb begin
        req_wr_d   = 1'b0;
        req_rd_d   = 1'b0;
        req_addr_d = req_addr_q;
        req_din_d  = req_din_q;
        req_inj_d  = 1'b0;
        if (bus.addr_en) begin
          req_wr_d   = acc_wr;
          req_rd_d   = acc_rd;
          req_addr_d = bus.addr;
          req_din_d  = bus.din;
          req_inj_d  = bus.inj_par;
        end
      end

      always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
          req_wr_q   <= 1'b0;
          req_rd_q   <= 1'b0;
          req_addr_q <= '0;
          req_din_q  <= '0;
          req_inj_q  <= 1'b0;
        end else begin
          req_wr_q   <= req_wr_d;
          req_rd_q   <= req_rd_d;
          req_addr_q <= req_addr_d;
          req_din_q  <= req_din_d;
          req_inj_q  <= req_inj_d;
        end
      end

      assign req_wr   = req_wr_q;
      assign req_rd   = req_rd_q;
      assign req_addr = req_addr_q;
      assign req_din  = req_din_q;
      assign req_inj  = req_inj_q;
    end else begin : g_addr_comb
      assign req_wr   = acc_wr;
      assign req_rd   = acc_rd;
      assign req_addr = bus.addr;
      assign req_din  = bus.din;
      assign req_inj  = bus.inj_par;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Memory stage
  // ---------------------------------------------------------------------
  logic               in_range;
  logic [c_idx_w-1:0] mem_idx;

  always_comb begin
    in_range = ({1'b0, req_addr} < c_depth);
    mem_idx  = req_addr[c_idx_w-1:0];
  end

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  // Storage is never reset; rst gates the write so a request that is
  // combinationally present while reset is asserted cannot land.
  always_ff @(posedge clk1) begin
    if (rst && req_wr && in_range) begin
      mem[mem_idx] <= req_din;
    end
  end

  logic rd_bit;

  generate
    if (PARITY_ENABLE != 0) begin : g_par
      logic par_mem [MEM_DEPTH];

      always_ff @(posedge clk1) begin
        if (rst && req_wr && in_range) begin
          par_mem[mem_idx] <= (^req_din) ^ req_inj;
        end
      end

      assign rd_bit = in_range ? par_mem[mem_idx] : 1'b0;
    end else begin : g_no_par
      assign rd_bit = 1'b0;
    end
  endgenerate

  logic                 rd_valid_q, rd_valid_d;
  logic [MEM_WIDTH-1:0] rd_data_q,  rd_data_d;
  logic                 rd_perr_q,  rd_perr_d;
  logic                 oor_q,      oor_d;

  // Read data holds between reads so an unpipelined output stays stable.
  // Out-of-range reads return zero with a zero stored bit, so no error.
  always_comb begin
    rd_valid_d = req_rd;
    rd_data_d  = rd_data_q;
    rd_perr_d  = rd_perr_q;
    oor_d      = (req_rd | req_wr) & ~in_range;
    if (req_rd) begin
      rd_data_d = in_range ? mem[mem_idx] : '0;
      rd_perr_d = (^rd_data_d) ^ rd_bit;
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_perr_q  <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_perr_q  <= rd_perr_d;
      oor_q      <= oor_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  logic [MEM_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_perr;

  generate
    if (DOUT_PIPELINE != 0) begin : g_dout_pipe
      logic [MEM_WIDTH-1:0] dout_q,  dout_d;
      logic                 valid_q, valid_d;
      logic                 perr_q,  perr_d;

      // Only a fresh read result updates dout; a result arriving while
      // dout_en is low is dropped rather than loaded on a later cycle.
      always_comb begin
        dout_d  = dout_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        if (bus.dout_en) begin
          valid_d = rd_valid_q;
          if (rd_valid_q) begin
            dout_d = rd_data_q;
            perr_d = rd_perr_q;
          end
        end
      end

      always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
          perr_q  <= 1'b0;
        end else begin
          dout_q  <= dout_d;
          valid_q <= valid_d;
          perr_q  <= perr_d;
        end
      end

      assign out_data  = dout_q;
      assign out_valid = valid_q;
      assign out_perr  = perr_q;
    end else begin : g_dout_comb
      assign out_data  = rd_data_q;
      assign out_valid = rd_valid_q;
      assign out_perr  = rd_perr_q;
    end
  endgenerate

  assign bus.dout       = out_data;
  assign bus.dout_valid = out_valid;
  assign bus.parity_out = (PARITY_ENABLE != 0) ? ^out_data : 1'b0;
  assign bus.parity_err = (PARITY_ENABLE != 0) ? out_perr : 1'b0;
  assign bus.addr_oor   = oor_q;

  // Inputs that some parameter sets leave unread.
  logic unused_sink;
  assign unused_sink = ^{bus.addr_en, bus.dout_en, req_inj};

endmodule
`default_nettype wire

// File: tb/tb_spr_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_spr_pipe                                              |
// | Description : Directed bench for spr_pipe. Instance A uses default     |
// |               parameters; instance B uses a registered request stage,  |
// |               unregistered output, no parity and a 1000-word depth.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_spr_pipe;

  logic clk1;
  logic rst;
  int   n_checks;
  int   n_errors;

  spr_pipe_if #(.MEM_WIDTH(16), .ADD_SIZE(10)) bus_a ();
  spr_pipe_if #(.MEM_WIDTH(16), .ADD_SIZE(10)) bus_b ();

  spr_pipe u_dut_a (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus_a)
  );

  spr_pipe #(
    .MEM_WIDTH     (16),
    .ADD_SIZE      (10),
    .MEM_DEPTH     (1000),
    .ADDR_PIPELINE (1),
    .DOUT_PIPELINE (0),
    .PARITY_ENABLE (0)
  ) u_dut_b (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus_b)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic idle_a();
    bus_a.blk_sel = 1'b0; bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
    bus_a.addr = '0; bus_a.din = '0; bus_a.inj_par = 1'b0;
    bus_a.addr_en = 1'b1; bus_a.dout_en = 1'b1;
  endtask

  task automatic idle_b();
    bus_b.blk_sel = 1'b0; bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0;
    bus_b.addr = '0; bus_b.din = '0; bus_b.inj_par = 1'b0;
    bus_b.addr_en = 1'b1; bus_b.dout_en = 1'b1;
  endtask

  task automatic drive_a(input logic wr, input logic rd, input logic [9:0] a,
                         input logic [15:0] d, input logic inj);
    bus_a.blk_sel = 1'b1; bus_a.wr_en = wr; bus_a.rd_en = rd;
    bus_a.addr = a; bus_a.din = d; bus_a.inj_par = inj;
  endtask

  task automatic drive_b(input logic wr, input logic rd, input logic [9:0] a,
                         input logic [15:0] d, input logic inj, input logic aen);
    bus_b.blk_sel = 1'b1; bus_b.wr_en = wr; bus_b.rd_en = rd;
    bus_b.addr = a; bus_b.din = d; bus_b.inj_par = inj; bus_b.addr_en = aen;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    idle_a();
    idle_b();
    @(negedge clk1);
    @(negedge clk1);
    n_checks++;
    if ({bus_a.dout, bus_a.dout_valid, bus_a.parity_err, bus_a.addr_oor, bus_a.parity_out} !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_a: dout=%h valid=%b perr=%b oor=%b pout=%b, required all zero",
               bus_a.dout, bus_a.dout_valid, bus_a.parity_err, bus_a.addr_oor, bus_a.parity_out);
    end
    n_checks++;
    if ({bus_b.dout, bus_b.dout_valid, bus_b.parity_err, bus_b.addr_oor} !== 19'h0) begin
      n_errors++;
      $display("FAIL reset_b: dout=%h valid=%b perr=%b oor=%b, required all zero",
               bus_b.dout, bus_b.dout_valid, bus_b.parity_err, bus_b.addr_oor);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk1); drive_a(1'b1, 1'b0, 10'h010, 16'hA5A5, 1'b0);
    @(negedge clk1); drive_a(1'b0, 1'b1, 10'h010, 16'h0000, 1'b0);
    @(negedge clk1);
    idle_a();
    n_checks++;
    if (bus_a.dout_valid !== 1'b0) begin
      n_errors++; $display("FAIL basic_early_valid: valid=%b required 0", bus_a.dout_valid);
    end
    @(negedge clk1);
    n_checks++;
    if (bus_a.dout_valid !== 1'b1 || bus_a.dout !== 16'hA5A5) begin
      n_errors++; $display("FAIL basic_read: valid=%b dout=%h required 1 a5a5", bus_a.dout_valid, bus_a.dout);
    end
    n_checks++;
    if (bus_a.parity_out !== 1'b0 || bus_a.parity_err !== 1'b0) begin
      n_errors++; $display("FAIL basic_parity: pout=%b perr=%b required 0 0", bus_a.parity_out, bus_a.parity_err);
    end
    @(negedge clk1);
    n_checks++;
    if (bus_a.dout_valid !== 1'b0 || bus_a.dout !== 16'hA5A5) begin
      n_errors++; $display("FAIL basic_hold: valid=%b dout=%h required 0 a5a5", bus_a.dout_valid, bus_a.dout);
    end
  endtask

  task automatic test_parity();
    // Instance A: injected parity fault, top address in range
    @(negedge clk1); drive_a(1'b1, 1'b0, 10'h3FF, 16'h0001, 1'b1);
    @(negedge clk1);
    n_checks++;
    if (bus_a.addr_oor !== 1'b0) begin
      n_errors++; $display("FAIL parity_top_addr_oor: oor=%b required 0", bus_a.addr_oor);
    end
    drive_a(1'b0, 1'b1, 10'h3FF, 16'h0000, 1'b0);
    @(negedge clk1); idle_a();
    @(negedge clk1);
    n_checks++;
    if (bus_a.dout_valid !== 1'b1 || bus_a.dout !== 16'h0001) begin
      n_errors++; $display("FAIL parity_a_read: valid=%b dout=%h required 1 0001", bus_a.dout_valid, bus_a.dout);
    end
    n_checks++;
    if (bus_a.parity_out !== 1'b1 || bus_a.parity_err !== 1'b1) begin
      n_errors++; $display("FAIL parity_a_err: pout=%b perr=%b required 1 1", bus_a.parity_out, bus_a.parity_err);
    end
    // Instance B: parity disabled, latency 2
    @(negedge clk1); drive_b(1'b1, 1'b0, 10'h005, 16'h0001, 1'b1, 1'b1);
    @(negedge clk1); drive_b(1'b0, 1'b1, 10'h005, 16'h0000, 1'b0, 1'b1);
    @(negedge clk1); idle_b();
    @(negedge clk1);
    n_checks++;
    if (bus_b.dout_valid !== 1'b1 || bus_b.dout !== 16'h0001) begin
      n_errors++; $display("FAIL parity_b_read: valid=%b dout=%h required 1 0001", bus_b.dout_valid, bus_b.dout);
    end
    n_checks++;
    if (bus_b.parity_out !== 1'b0 || bus_b.parity_err !== 1'b0) begin
      n_errors++; $display("FAIL parity_b_disabled: pout=%b perr=%b required 0 0", bus_b.parity_out, bus_b.parity_err);
    end
  endtask

  task automatic test_back_to_back();
    int          pulses;
    logic        exp_v;
    logic [15:0] exp_d;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk1); drive_a(1'b1, 1'b0, 10'(i), 16'h1000 + 16'(i), 1'b0);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk1);
      // Read k appears two cycles after issue; read 3 is dropped by the stall.
      exp_v = (c >= 2 && c <= 9 && c != 5);
      n_checks++;
      if (bus_a.dout_valid !== exp_v) begin
        n_errors++; $display("FAIL b2b_valid[%0d]: valid=%b required %b", c, bus_a.dout_valid, exp_v);
      end
      if (c >= 2) begin
        if (c == 5)      exp_d = 16'h1002;
        else if (c >= 10) exp_d = 16'h1007;
        else             exp_d = 16'h1000 + 16'(c - 2);
        n_checks++;
        if (bus_a.dout !== exp_d) begin
          n_errors++; $display("FAIL b2b_dout[%0d]: dout=%h required %h", c, bus_a.dout, exp_d);
        end
      end
      if (bus_a.dout_valid === 1'b1) pulses++;
      if (c < 8) drive_a(1'b0, 1'b1, 10'(c), 16'h0000, 1'b0);
      else       idle_a();
      bus_a.dout_en = (c != 4);
    end
    idle_a();
    n_checks++;
    if (pulses != 7) begin
      n_errors++; $display("FAIL b2b_pulse_count: pulses=%0d required 7", pulses);
    end
  endtask

  task automatic test_bubbles();
    @(negedge clk1); drive_a(1'b1, 1'b0, 10'h040, 16'h1234, 1'b0);
    @(negedge clk1); drive_a(1'b1, 1'b1, 10'h040, 16'hFFFF, 1'b0);
    @(negedge clk1);
    // Deselected read must also be ignored.
    drive_a(1'b0, 1'b1, 10'h040, 16'h0000, 1'b0);
    bus_a.blk_sel = 1'b0;
    @(negedge clk1);
    n_checks++;
    if (bus_a.dout_valid !== 1'b0) begin
      n_errors++; $display("FAIL bubble_both_valid: valid=%b required 0", bus_a.dout_valid);
    end
    drive_a(1'b0, 1'b1, 10'h040, 16'h0000, 1'b0);
    @(negedge clk1);
    idle_a();
    n_checks++;
    if (bus_a.dout_valid !== 1'b0) begin
      n_errors++; $display("FAIL bubble_blksel_valid: valid=%b required 0", bus_a.dout_valid);
    end
    @(negedge clk1);
    n_checks++;
    if (bus_a.dout_valid !== 1'b1 || bus_a.dout !== 16'h1234) begin
      n_errors++; $display("FAIL bubble_no_write: valid=%b dout=%h required 1 1234", bus_a.dout_valid, bus_a.dout);
    end
  endtask

  task automatic test_addr_pipe();
    @(negedge clk1); drive_b(1'b1, 1'b0, 10'h010, 16'h7E7E, 1'b0, 1'b1);
    @(negedge clk1); drive_b(1'b0, 1'b1, 10'h010, 16'h0000, 1'b0, 1'b1);
    @(negedge clk1);
    idle_b();
    n_checks++;
    if (bus_b.dout_valid !== 1'b0) begin
      n_errors++; $display("FAIL apipe_early_valid: valid=%b required 0", bus_b.dout_valid);
    end
    @(negedge clk1);
    n_checks++;
    if (bus_b.dout_valid !== 1'b1 || bus_b.dout !== 16'h7E7E) begin
      n_errors++; $display("FAIL apipe_read: valid=%b dout=%h required 1 7e7e", bus_b.dout_valid, bus_b.dout);
    end
    drive_b(1'b0, 1'b1, 10'h010, 16'h0000, 1'b0, 1'b0);
    @(negedge clk1);
    drive_b(1'b1, 1'b0, 10'h010, 16'h0000, 1'b0, 1'b0);
    @(negedge clk1);
    n_checks++;
    if (bus_b.dout_valid !== 1'b0 || bus_b.dout !== 16'h7E7E) begin
      n_errors++; $display("FAIL apipe_bubble: valid=%b dout=%h required 0 7e7e", bus_b.dout_valid, bus_b.dout);
    end
    drive_b(1'b0, 1'b1, 10'h010, 16'h0000, 1'b0, 1'b1);
    @(negedge clk1); idle_b();
    @(negedge clk1);
    n_checks++;
    if (bus_b.dout_valid !== 1'b1 || bus_b.dout !== 16'h7E7E) begin
      n_errors++; $display("FAIL apipe_write_dropped: valid=%b dout=%h required 1 7e7e", bus_b.dout_valid, bus_b.dout);
    end
  endtask

  task automatic test_oor();
    @(negedge clk1); drive_b(1'b1, 1'b0, 10'd1000, 16'hBEEF, 1'b0, 1'b1);
    @(negedge clk1); idle_b();
    @(negedge clk1);
    n_checks++;
    if (bus_b.addr_oor !== 1'b1) begin
      n_errors++; $display("FAIL oor_write_pulse: oor=%b required 1", bus_b.addr_oor);
    end
    drive_b(1'b0, 1'b1, 10'd1000, 16'h0000, 1'b0, 1'b1);
    @(negedge clk1);
    idle_b();
    n_checks++;
    if (bus_b.addr_oor !== 1'b0) begin
      n_errors++; $display("FAIL oor_pulse_width: oor=%b required 0", bus_b.addr_oor);
    end
    @(negedge clk1);
    n_checks++;
    if (bus_b.addr_oor !== 1'b1 || bus_b.dout_valid !== 1'b1 || bus_b.dout !== 16'h0000 || bus_b.parity_err !== 1'b0) begin
      n_errors++; $display("FAIL oor_read: oor=%b valid=%b dout=%h perr=%b required 1 1 0000 0",
                           bus_b.addr_oor, bus_b.dout_valid, bus_b.dout, bus_b.parity_err);
    end
    drive_b(1'b1, 1'b0, 10'd999, 16'h1111, 1'b0, 1'b1);
    @(negedge clk1); drive_b(1'b0, 1'b1, 10'd999, 16'h0000, 1'b0, 1'b1);
    @(negedge clk1);
    idle_b();
    n_checks++;
    if (bus_b.addr_oor !== 1'b0) begin
      n_errors++; $display("FAIL oor_last_word_write: oor=%b required 0", bus_b.addr_oor);
    end
    @(negedge clk1);
    n_checks++;
    if (bus_b.addr_oor !== 1'b0 || bus_b.dout_valid !== 1'b1 || bus_b.dout !== 16'h1111) begin
      n_errors++; $display("FAIL oor_last_word_read: oor=%b valid=%b dout=%h required 0 1 1111",
                           bus_b.addr_oor, bus_b.dout_valid, bus_b.dout);
    end
    drive_b(1'b1, 1'b1, 10'h010, 16'h0000, 1'b0, 1'b1);
    @(negedge clk1); idle_b();
    @(negedge clk1);
    n_checks++;
    if (bus_b.dout_valid !== 1'b0 || bus_b.addr_oor !== 1'b0) begin
      n_errors++; $display("FAIL oor_both_ops: valid=%b oor=%b required 0 0", bus_b.dout_valid, bus_b.addr_oor);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk1); drive_a(1'b1, 1'b0, 10'h020, 16'h5A5A, 1'b0);
    @(negedge clk1); drive_a(1'b0, 1'b1, 10'h020, 16'h0000, 1'b0);
    @(negedge clk1); drive_a(1'b1, 1'b0, 10'h020, 16'hFFFF, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus_a.dout !== 16'h0000 || bus_a.dout_valid !== 1'b0 || bus_a.parity_err !== 1'b0 || bus_a.addr_oor !== 1'b0) begin
      n_errors++; $display("FAIL rst_async: dout=%h valid=%b perr=%b oor=%b required 0000 0 0 0",
                           bus_a.dout, bus_a.dout_valid, bus_a.parity_err, bus_a.addr_oor);
    end
    @(negedge clk1);
    n_checks++;
    if (bus_a.dout_valid !== 1'b0 || bus_a.dout !== 16'h0000) begin
      n_errors++; $display("FAIL rst_held: valid=%b dout=%h required 0 0000", bus_a.dout_valid, bus_a.dout);
    end
    rst = 1'b1;
    drive_a(1'b0, 1'b1, 10'h020, 16'h0000, 1'b0);
    @(negedge clk1);
    idle_a();
    n_checks++;
    if (bus_a.dout_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_flushed: valid=%b required 0", bus_a.dout_valid);
    end
    @(negedge clk1);
    n_checks++;
    if (bus_a.dout_valid !== 1'b1 || bus_a.dout !== 16'h5A5A) begin
      n_errors++; $display("FAIL rst_mem_kept: valid=%b dout=%h required 1 5a5a", bus_a.dout_valid, bus_a.dout);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_bubbles();
    test_addr_pipe();
    test_oor();
    test_reset_mid();
    @(negedge clk1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
